// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters
// (channel 0 = EXU, channel 1 = branch/CSR path).
// A single result slot holds the last ALU result for its owning channel
// until that channel takes it through the valid/ready handshake.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN
//   defined   -> channel 0 always wins contention (channel 1 may starve)
//   undefined -> round-robin between the two channels (default)
module alu_arbiter #(
    parameter int BW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [BW-1:0] req_d1_0,
    input  logic [BW-1:0] req_d1_1,
    input  logic [BW-1:0] req_d2_0,
    input  logic [BW-1:0] req_d2_1,
    input  logic [3:0]    req_op_0,
    input  logic [3:0]    req_op_1,
    output logic [BW-1:0] alu_d1,
    output logic [BW-1:0] alu_d2,
    output logic [3:0]    alu_choice,
    input  logic [BW-1:0] alu_res,
    input  logic          alu_of,
    output logic [1:0]    resp_valid,
    input  logic [1:0]    resp_ready,
    output logic [BW-1:0] resp_res,
    output logic          resp_of
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_owner;
    logic          r_last;
    logic [BW-1:0] r_res;
    logic          r_of;
    logic [1:0]    r_resp_valid;

    logic          w_slot_free;
    logic          w_owner_taking;
    logic          w_grant_vld;
    logic          w_grant_ch;

    // The slot can take a new result when empty or when its owner drains it this cycle.
    always_comb begin
        w_owner_taking = 1'b0;
        w_slot_free    = 1'b0;
        if (r_state == HOLD) begin
            w_owner_taking = resp_ready[r_owner];
            w_slot_free    = resp_ready[r_owner];
        end else begin
            w_owner_taking = 1'b0;
            w_slot_free    = 1'b1;
        end
    end

    // Pick at most one channel; contention goes to the channel not served last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = 1'b0;
        if (w_slot_free) begin
            case (req_valid)
                2'b01: begin
                    w_grant_vld = 1'b1;
                    w_grant_ch  = 1'b0;
                end
                2'b10: begin
                    w_grant_vld = 1'b1;
                    w_grant_ch  = 1'b1;
                end
                2'b11: begin
                    w_grant_vld = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                    w_grant_ch  = 1'b0;
`else
                    w_grant_ch  = ~r_last;
`endif
                end
                default: begin
                    w_grant_vld = 1'b0;
                    w_grant_ch  = 1'b0;
                end
            endcase
        end else begin
            w_grant_vld = 1'b0;
            w_grant_ch  = 1'b0;
        end
    end

    // One-hot accept and ALU operand steering from the granted channel; zeros when idle.
    always_comb begin
        req_ready  = 2'b00;
        alu_d1     = {BW{1'b0}};
        alu_d2     = {BW{1'b0}};
        alu_choice = 4'd0;
        if (w_grant_vld) begin
            if (w_grant_ch) begin
                req_ready  = 2'b10;
                alu_d1     = req_d1_1;
                alu_d2     = req_d2_1;
                alu_choice = req_op_1;
            end else begin
                req_ready  = 2'b01;
                alu_d1     = req_d1_0;
                alu_d2     = req_d2_0;
                alu_choice = req_op_0;
            end
        end else begin
            req_ready  = 2'b00;
            alu_d1     = {BW{1'b0}};
            alu_d2     = {BW{1'b0}};
            alu_choice = 4'd0;
        end
    end

    // Slot FSM: capture the ALU result on accept, release it on the owner's handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_res        <= {BW{1'b0}};
            r_of         <= 1'b0;
            r_resp_valid <= 2'b00;
        end else if (w_grant_vld) begin
            r_state      <= HOLD;
            r_owner      <= w_grant_ch;
            r_last       <= w_grant_ch;
            r_res        <= alu_res;
            r_of         <= alu_of;
            r_resp_valid <= w_grant_ch ? 2'b10 : 2'b01;
        end else if (w_owner_taking) begin
            r_state      <= IDLE;
            r_resp_valid <= 2'b00;
        end else begin
            r_state      <= r_state;
            r_resp_valid <= r_resp_valid;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_res   = r_res;
    assign resp_of    = r_of;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters: channel 0 (EXU) and channel 1 (branch/CSR path). It grants one request per accept, drives the ALU operands and opcode, and registers the result and overflow flag. It then presents them on the owning channel's response port under a valid/ready handshake. It sits between the issue logic and the single ALU instance, replacing per-unit ALU copies.

## Interface
Parameters:
- BW, 32, operand/result width; must match the ALU's BW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-channel request valid, bit i = channel i.
- req_ready  out  2  per-channel request accept.
- req_d1_0 / req_d1_1  in  BW  operand 1, channels 0 and 1.
- req_d2_0 / req_d2_1  in  BW  operand 2, channels 0 and 1.
- req_op_0 / req_op_1  in  4  ALU choice code, channels 0 and 1.
- alu_d1  out  BW  to ALU d1.
- alu_d2  out  BW  to ALU d2.
- alu_choice  out  4  to ALU choice.
- alu_res  in  BW  from ALU res.
- alu_of  in  1  from ALU overflow.
- resp_valid  out  2  per-channel response valid.
- resp_ready  in  2  per-channel response accept.
- resp_res  out  BW  registered result, shared by both channels.
- resp_of  out  1  registered overflow, shared by both channels.

## Operation
- States: IDLE (no result held) and HOLD (result held for `owner`).
- `slot_free` = (state==IDLE) || (state==HOLD && resp_ready[owner]).
- Grant, combinational:
  - Only one channel valid: that channel.
  - Both valid: the channel ≠ `last`.
  - No grant when `slot_free` is 0.
- req_ready = one-hot grant, and zero when there is no grant. At most one bit is set per cycle.
- ALU drive, combinational:
  - alu_d1/alu_d2/alu_choice = the granted channel's fields.
  - With no grant, all are 0.
  - The ALU's result is used in the same cycle.
- On accept (req_valid[g] && req_ready[g]):
  - res_q ← alu_res; of_q ← alu_of; owner ← g; last ← g.
  - state ← HOLD.
- HOLD:
  - resp_valid = one-hot(owner).
  - resp_res = res_q; resp_of = of_q; these are stable until the handshake.
  - resp_ready[owner] with no new accept: state ← IDLE.
  - resp_ready[owner] together with a new accept in the same cycle: stay in HOLD with the new data (back-to-back).
- resp_ready of the non-owning channel is ignored.
- Requester obligation: req fields stay stable while req_valid is high and req_ready is low. The arbiter does not buffer unaccepted requests.
- Overflow is passed through unchanged for all opcodes. Opcodes are not decoded; an opcode unknown to the ALU returns 0 per the ALU default.

## Timing
- Reset values:
  - state=IDLE, res_q=0, of_q=0, owner=0, last=1 (channel 0 wins the first contention).
  - req_ready=0 whenever no request is valid; resp_valid=0; resp_res=0; resp_of=0.
  - alu_d1=0, alu_d2=0, alu_choice=0.
- Latency: a request accepted in cycle N gives resp_valid in cycle N+1.
- Throughput: 1 op/cycle sustained when the owner holds resp_ready high.
- Single-channel streaming: repeated grants to the same channel are allowed whenever the other channel is idle.
- Fairness under continuous contention: grants alternate 0,1,0,1…; no channel waits more than one grant.
- Reset mid-HOLD: the held response is discarded, resp_valid=0 in the next cycle, and no response is replayed.
- rst high in the same cycle as a valid request: the grant is computed combinationally, but no state is updated. The requester must re-present after reset.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: channel 0 has strict priority whenever both are valid. `last` is still tracked but does not affect the grant. Channel 1 may starve.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset, then ch0 valid, d1=5, d2=3, op=add → req_ready=2'b01 same cycle; next cycle resp_valid=2'b01, resp_res=8, resp_of=0.
- Both channels valid, ops add(1,1) on ch0 and sub(9,4) on ch1, resp_ready=2'b11 held → grants 01,10,01,10…; responses 2 (ch0) then 5 (ch1) on consecutive cycles.
- ch1 request sub(0x80000000,1), resp_ready[1]=0 for 3 cycles → resp_valid=2'b10 stable, resp_res=0x7FFFFFFF, resp_of=1 for all 3 cycles. A new request on ch0 sees req_ready=0 throughout and is accepted in the cycle resp_ready[1] rises.
- HOLD for ch0 with resp_ready=2'b10 → ignored; state remains HOLD.
- HOLD for ch0, assert rst for 1 cycle → resp_valid=0, resp_res=0 next cycle; a later ch0+ch1 contention grants ch0 first.
- With ALU_ARB_FIXED_PRIO_EN defined and both valid for 4 cycles (resp_ready=2'b11) → req_ready=2'b01 in every cycle; ch1 is never granted.
